// File: rtl/pong_session_ctrl.sv
// Match-level session controller for the pong engine: session FSM, scoring,
// attract demo and paddle command generation (buttons or CPU tracker).
module pong_session_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int IDLE_FRAMES  = 1800,
    parameter int CPU_REACTION = 4,
    parameter int CPU_DEADBAND = 4,
    parameter int PADDLE_H     = 48,
    parameter int BALL_H       = 8
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_p1_up,
    input  logic       btn_p1_down,
    input  logic       btn_p2_up,
    input  logic       btn_p2_down,
    input  logic [1:0] mode_sel,
    input  logic [9:0] sq_ypos,
    input  logic [9:0] pdl1_ypos,
    input  logic [9:0] pdl2_ypos,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic       up_p1,
    output logic       down_p1,
    output logic       up_p2,
    output logic       down_p2,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       serve_en,
    output logic       game_startup,
    output logic       game_over,
    output logic       attract
);

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int IW = (IDLE_FRAMES > 1) ? $clog2(IDLE_FRAMES) : 1;
    localparam int SW = (SERVE_FRAMES > 0) ? $clog2(SERVE_FRAMES + 1) : 1;

    localparam logic [SW-1:0] SERVE_LD  = SW'(SERVE_FRAMES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_FRAMES - 1);
    localparam logic [3:0]    WIN       = 4'(WIN_SCORE);
    localparam logic [10:0]   HALF_B    = 11'(BALL_H / 2);
    localparam logic [10:0]   HALF_P    = 11'(PADDLE_H / 2);
    localparam logic signed [10:0] DB_P = 11'(CPU_DEADBAND);
    localparam logic signed [10:0] DB_N = -DB_P;

    state_t          state;
    state_t          state_n;
    logic            attract_n;
    logic [3:0]      s1_n;
    logic [3:0]      s2_n;
    logic [IW-1:0]   idle_cnt;
    logic [IW-1:0]   idle_n;
    logic [SW-1:0]   serve_cnt;
    logic [SW-1:0]   serve_n;
    logic            any_btn;
    logic            any_prev;
    logic            start;
    logic            idle_done;

    assign any_btn   = btn_p1_up | btn_p1_down | btn_p2_up | btn_p2_down;
    assign start     = any_btn & ~any_prev;
    assign idle_done = frame_tick && (idle_cnt == IDLE_LAST);

    // An attract-mode start edge only cancels the demo; it never starts a game.
    always_comb begin
        state_n   = state;
        attract_n = attract;
        s1_n      = score_p1;
        s2_n      = score_p2;
        idle_n    = idle_cnt;
        serve_n   = serve_cnt;
        if (start && attract) begin
            state_n   = TITLE;
            attract_n = 1'b0;
            s1_n      = '0;
            s2_n      = '0;
            idle_n    = '0;
        end else begin
            unique case (state)
                TITLE: begin
                    if (start || idle_done) begin
                        state_n   = SERVE;
                        attract_n = !start;
                        s1_n      = '0;
                        s2_n      = '0;
                        serve_n   = SERVE_LD;
                        idle_n    = '0;
                    end else if (frame_tick) begin
                        idle_n = idle_cnt + 1'b1;
                    end
                end
                SERVE: begin
                    if (serve_cnt == '0) begin
                        state_n = PLAY;
                    end else if (frame_tick) begin
                        serve_n = serve_cnt - 1'b1;
                    end
                end
                PLAY: begin
                    if (point_p1 && point_p2) begin
                        state_n = SERVE;
                        serve_n = SERVE_LD;
                    end else if (point_p1) begin
                        s1_n    = score_p1 + 4'd1;
                        state_n = (s1_n == WIN) ? OVER : SERVE;
                        serve_n = SERVE_LD;
                        idle_n  = '0;
                    end else if (point_p2) begin
                        s2_n    = score_p2 + 4'd1;
                        state_n = (s2_n == WIN) ? OVER : SERVE;
                        serve_n = SERVE_LD;
                        idle_n  = '0;
                    end
                end
                OVER: begin
                    if (start || idle_done) begin
                        state_n   = TITLE;
                        attract_n = 1'b0;
                        idle_n    = '0;
                    end else if (frame_tick) begin
                        idle_n = idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = TITLE;
                end
            endcase
        end
    end

    logic [9:0]  oldest;
    logic [10:0] target;
    logic [1:0]  trk1;
    logic [1:0]  trk2;
    logic [1:0]  cpu1;
    logic [1:0]  cpu2;
    logic [1:0]  cmd1;
    logic [1:0]  cmd2;
    logic [1:0]  hum1;
    logic [1:0]  hum2;
    logic [1:0]  pad1;
    logic [1:0]  pad2;
    logic        active;
    logic        cpu_p1;
    logic        cpu_p2;

    // The incoming sample counts as the newest history entry on its tick.
    generate
        if (CPU_REACTION > 1) begin : g_hist
            logic [9:0] hist [CPU_REACTION-1];
            always_ff @(posedge clk_0) begin
                if (rst) begin
                    for (int i = 0; i < CPU_REACTION - 1; i++) begin
                        hist[i] <= '0;
                    end
                end else if (frame_tick) begin
                    hist[0] <= sq_ypos;
                    for (int i = 1; i < CPU_REACTION - 1; i++) begin
                        hist[i] <= hist[i-1];
                    end
                end
            end
            assign oldest = hist[CPU_REACTION-2];
        end else begin : g_nohist
            assign oldest = sq_ypos;
        end
    endgenerate

    function automatic logic [1:0] track(
        input logic [10:0] tgt,
        input logic [9:0]  pdl
    );
        logic signed [10:0] diff;
        diff = $signed(tgt - ({1'b0, pdl} + HALF_P));
        return {(diff < DB_N), (diff > DB_P)};
    endfunction

    assign target = {1'b0, oldest} + HALF_B;
    assign trk1   = track(target, pdl1_ypos);
    assign trk2   = track(target, pdl2_ypos);
    assign cmd1   = frame_tick ? trk1 : cpu1;
    assign cmd2   = frame_tick ? trk2 : cpu2;

    assign hum1 = {btn_p1_up & ~btn_p1_down, btn_p1_down & ~btn_p1_up};
    assign hum2 = {btn_p2_up & ~btn_p2_down, btn_p2_down & ~btn_p2_up};

    assign active = (state == SERVE) || (state == PLAY);
    assign cpu_p1 = attract || (mode_sel == 2'b10);
    assign cpu_p2 = attract || (mode_sel == 2'b01) || (mode_sel == 2'b10);

    assign pad1 = !active ? 2'b00 : (cpu_p1 ? cmd1 : hum1);
    assign pad2 = !active ? 2'b00 : (cpu_p2 ? cmd2 : hum2);

    always_ff @(posedge clk_0) begin
        if (rst) begin
            state        <= TITLE;
            game_startup <= 1'b1;
            game_over    <= 1'b0;
            serve_en     <= 1'b0;
            attract      <= 1'b0;
            score_p1     <= '0;
            score_p2     <= '0;
            idle_cnt     <= '0;
            serve_cnt    <= '0;
            any_prev     <= 1'b1;
            cpu1         <= '0;
            cpu2         <= '0;
            up_p1        <= 1'b0;
            down_p1      <= 1'b0;
            up_p2        <= 1'b0;
            down_p2      <= 1'b0;
        end else begin
            state        <= state_n;
            game_startup <= (state_n == TITLE);
            game_over    <= (state_n == OVER);
            serve_en     <= (state_n == PLAY);
            attract      <= attract_n;
            score_p1     <= s1_n;
            score_p2     <= s2_n;
            idle_cnt     <= idle_n;
            serve_cnt    <= serve_n;
            any_prev     <= any_btn;
            if (frame_tick) begin
                cpu1 <= trk1;
                cpu2 <= trk2;
            end
            {up_p1, down_p1} <= pad1;
            {up_p2, down_p2} <= pad2;
        end
    end

endmodule

// File: tb/tb_pong_session_ctrl.sv
// Scoreboard bench for pong_session_ctrl: directed scenarios plus random
// traffic, checked every cycle against a behavioural session model.
module tb_pong_session_ctrl;

    localparam int WIN   = 3;
    localparam int SF    = 60;
    localparam int IDLE  = 10;
    localparam int REACT = 4;
    localparam int DB    = 4;
    localparam int PH    = 48;
    localparam int BH    = 8;

    logic       clk_0 = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_p1_up = 1'b0;
    logic       btn_p1_down = 1'b0;
    logic       btn_p2_up = 1'b0;
    logic       btn_p2_down = 1'b0;
    logic [1:0] mode_sel = 2'b00;
    logic [9:0] sq_ypos = '0;
    logic [9:0] pdl1_ypos = '0;
    logic [9:0] pdl2_ypos = '0;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic       up_p1, down_p1, up_p2, down_p2;
    logic [3:0] score_p1, score_p2;
    logic       serve_en, game_startup, game_over, attract;

    pong_session_ctrl #(
        .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .IDLE_FRAMES(IDLE),
        .CPU_REACTION(REACT), .CPU_DEADBAND(DB),
        .PADDLE_H(PH), .BALL_H(BH)
    ) dut (
        .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick),
        .btn_p1_up(btn_p1_up), .btn_p1_down(btn_p1_down),
        .btn_p2_up(btn_p2_up), .btn_p2_down(btn_p2_down),
        .mode_sel(mode_sel), .sq_ypos(sq_ypos),
        .pdl1_ypos(pdl1_ypos), .pdl2_ypos(pdl2_ypos),
        .point_p1(point_p1), .point_p2(point_p2),
        .up_p1(up_p1), .down_p1(down_p1),
        .up_p2(up_p2), .down_p2(down_p2),
        .score_p1(score_p1), .score_p2(score_p2),
        .serve_en(serve_en), .game_startup(game_startup),
        .game_over(game_over), .attract(attract)
    );

    always #5 clk_0 = ~clk_0;

    typedef logic [15:0] vec_t;
    vec_t expq[$];
    vec_t mon_e;
    vec_t mon_a;
    int   checks = 0;
    int   failures = 0;

    // Model: 0 title, 1 serve, 2 play, 3 game over.
    int m_state, m_att, m_s1, m_s2, m_idle, m_cnt, m_prev;
    int hist[$];
    bit c1u, c1d, c2u, c2d;
    bit o_u1, o_d1, o_u2, o_d2;
    bit rnd_pos = 0;
    bit rnd_btn = 0;

    function automatic void track(input int y, input int pdl,
                                  output bit u, output bit d);
        int diff;
        diff = (y + BH / 2) - (pdl + PH / 2);
        u = (diff < -DB);
        d = (diff > DB);
    endfunction

    task automatic model_step();
        bit anyb, start, gate, cpu1, cpu2;
        anyb = btn_p1_up | btn_p1_down | btn_p2_up | btn_p2_down;
        if (rst) begin
            m_state = 0; m_att = 0; m_s1 = 0; m_s2 = 0;
            m_idle = 0; m_cnt = 0; m_prev = 1;
            hist.delete();
            repeat (REACT) hist.push_back(0);
            c1u = 0; c1d = 0; c2u = 0; c2d = 0;
            o_u1 = 0; o_d1 = 0; o_u2 = 0; o_d2 = 0;
            return;
        end
        start = anyb && (m_prev == 0);
        m_prev = anyb;
        if (frame_tick) begin
            hist.push_front(int'(sq_ypos));
            void'(hist.pop_back());
            track(hist[$], int'(pdl1_ypos), c1u, c1d);
            track(hist[$], int'(pdl2_ypos), c2u, c2d);
        end
        gate = (m_state == 1) || (m_state == 2);
        cpu1 = (m_att != 0) || (mode_sel == 2'b10);
        cpu2 = (m_att != 0) || (mode_sel == 2'b01) || (mode_sel == 2'b10);
        o_u1 = gate && (cpu1 ? c1u : (btn_p1_up && !btn_p1_down));
        o_d1 = gate && (cpu1 ? c1d : (btn_p1_down && !btn_p1_up));
        o_u2 = gate && (cpu2 ? c2u : (btn_p2_up && !btn_p2_down));
        o_d2 = gate && (cpu2 ? c2d : (btn_p2_down && !btn_p2_up));
        if (start && m_att != 0) begin
            m_state = 0; m_att = 0; m_s1 = 0; m_s2 = 0; m_idle = 0;
        end else begin
            case (m_state)
                0: if (start) begin
                    m_state = 1; m_att = 0; m_s1 = 0; m_s2 = 0;
                    m_cnt = SF; m_idle = 0;
                end else if (frame_tick) begin
                    m_idle++;
                    if (m_idle == IDLE) begin
                        m_state = 1; m_att = 1; m_s1 = 0; m_s2 = 0;
                        m_cnt = SF; m_idle = 0;
                    end
                end
                1: if (m_cnt == 0) m_state = 2;
                   else if (frame_tick) m_cnt--;
                2: if (point_p1 && point_p2) begin
                    m_state = 1; m_cnt = SF;
                end else if (point_p1) begin
                    m_s1++;
                    m_state = (m_s1 == WIN) ? 3 : 1;
                    m_cnt = SF; m_idle = 0;
                end else if (point_p2) begin
                    m_s2++;
                    m_state = (m_s2 == WIN) ? 3 : 1;
                    m_cnt = SF; m_idle = 0;
                end
                3: if (start) begin
                    m_state = 0; m_att = 0; m_idle = 0;
                end else if (frame_tick) begin
                    m_idle++;
                    if (m_idle == IDLE) begin
                        m_state = 0; m_att = 0; m_idle = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic vec_t pack_exp();
        return {o_u1, o_d1, o_u2, o_d2, 4'(m_s1), 4'(m_s2),
                (m_state == 2), (m_state == 0), (m_state == 3),
                (m_att != 0)};
    endfunction

    initial forever begin
        @(posedge clk_0);
        #1;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            mon_a = {up_p1, down_p1, up_p2, down_p2, score_p1, score_p2,
                     serve_en, game_startup, game_over, attract};
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL outputs t=%0t got=%h expected=%h",
                         $time, mon_a, mon_e);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic step();
        if (rnd_pos) begin
            sq_ypos   = 10'($urandom_range(0, 479));
            pdl1_ypos = 10'($urandom_range(0, 479));
            pdl2_ypos = 10'($urandom_range(0, 479));
        end
        if (rnd_btn && $urandom_range(0, 15) == 0) begin
            {btn_p1_up, btn_p1_down, btn_p2_up, btn_p2_down} = 4'($urandom);
        end
        model_step();
        expq.push_back(pack_exp());
        @(negedge clk_0);
    endtask

    task automatic tick_n(input int n, input int gap);
        repeat (n) begin
            repeat (gap) step();
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_pt(input bit a, input bit b);
        point_p1 = a;
        point_p2 = b;
        step();
        point_p1 = 1'b0;
        point_p2 = 1'b0;
    endtask

    task automatic serve_out();
        tick_n(SF, 1);
        step();
        chk("serve_to_play", serve_en, 1);
    endtask

    task automatic clr_btn();
        {btn_p1_up, btn_p1_down, btn_p2_up, btn_p2_down} = 4'b0000;
    endtask

    initial begin
        @(negedge clk_0);
        rst = 1'b1;
        btn_p1_up = 1'b1;
        repeat (3) step();
        chk("reset_startup", game_startup, 1);
        chk("reset_scores", {score_p1, score_p2}, 0);
        chk("reset_paddles", {up_p1, down_p1, up_p2, down_p2}, 0);
        rst = 1'b0;
        repeat (5) step();
        chk("held_no_start", game_startup, 1);
        btn_p1_up = 1'b0;
        repeat (2) step();
        btn_p1_up = 1'b1;
        step();
        chk("start_edge", game_startup, 0);
        btn_p1_up = 1'b0;

        rnd_pos = 1;
        rnd_btn = 1;
        tick_n(SF - 1, 1);
        chk("serve_59", serve_en, 0);
        tick_n(1, 1);
        chk("serve_60", serve_en, 0);
        step();
        chk("serve_rise", serve_en, 1);

        rnd_btn = 0;
        btn_p1_up = 1'b1;
        btn_p1_down = 1'b1;
        btn_p2_up = 1'b1;
        btn_p2_down = 1'b0;
        step();
        chk("conflict_p1", {up_p1, down_p1}, 0);
        chk("human_up_p2", {up_p2, down_p2}, 2);
        clr_btn();
        step();

        pulse_pt(1, 0);
        chk("p1_score1", score_p1, 1);
        chk("point_serve_fall", serve_en, 0);
        pulse_pt(0, 1);
        chk("p2_ignored_serve", score_p2, 0);
        serve_out();
        pulse_pt(1, 0);
        chk("p1_score2", score_p1, 2);
        serve_out();
        pulse_pt(1, 1);
        chk("let_scores", {score_p1, score_p2}, 8'h20);
        chk("let_serve", serve_en, 0);
        step();
        chk("let_serve_hold", serve_en, 0);
        serve_out();
        pulse_pt(1, 0);
        chk("win_score", score_p1, 3);
        chk("win_over", game_over, 1);
        chk("win_p2", score_p2, 0);
        pulse_pt(1, 0);
        chk("no_wrap", score_p1, 3);

        btn_p2_down = 1'b1;
        step();
        chk("over_to_title", game_startup, 1);
        chk("over_keep_score", score_p1, 3);
        clr_btn();
        step();
        btn_p2_down = 1'b1;
        step();
        chk("restart_clear", score_p1, 0);
        chk("restart_serve", game_startup, 0);
        clr_btn();

        rnd_pos = 0;
        mode_sel = 2'b01;
        pdl2_ypos = 10'd200;
        sq_ypos = 10'd300;
        tick_n(4, 2);
        chk("cpu_down", {up_p2, down_p2}, 1);
        sq_ypos = 10'd216;
        tick_n(4, 2);
        chk("cpu_deadband", {up_p2, down_p2}, 0);
        sq_ypos = 10'd100;
        tick_n(4, 2);
        chk("cpu_up", {up_p2, down_p2}, 2);
        mode_sel = 2'b00;
        step();
        chk("mode_to_human", {up_p2, down_p2}, 0);

        rnd_pos = 1;
        rnd_btn = 1;
        repeat (3000) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            point_p1 = ($urandom_range(0, 15) == 0);
            point_p2 = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) mode_sel = 2'($urandom);
            step();
        end
        frame_tick = 1'b0;
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        rnd_pos = 0;
        rnd_btn = 0;
        clr_btn();

        rst = 1'b1;
        step();
        chk("midgame_reset_title", game_startup, 1);
        chk("midgame_reset_scores", {score_p1, score_p2}, 0);
        rst = 1'b0;
        step();
        mode_sel = 2'b00;
        sq_ypos = 10'd300;
        pdl1_ypos = 10'd100;
        pdl2_ypos = 10'd100;
        tick_n(IDLE - 1, 1);
        chk("attract_early", attract, 0);
        tick_n(1, 1);
        chk("attract_on", attract, 1);
        chk("attract_serve", game_startup, 0);
        tick_n(4, 1);
        chk("attract_cpu1", {up_p1, down_p1}, 1);
        chk("attract_cpu2", {up_p2, down_p2}, 1);
        btn_p1_down = 1'b1;
        step();
        chk("attract_exit", attract, 0);
        chk("attract_title", game_startup, 1);
        chk("attract_scores", {score_p1, score_p2}, 0);
        step();
        chk("attract_held", game_startup, 1);
        clr_btn();
        repeat (2) step();
        chk("attract_no_start", game_startup, 1);
        btn_p1_down = 1'b1;
        step();
        chk("attract_next_start", game_startup, 0);
        clr_btn();
        repeat (3) step();

        @(posedge clk_0);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_session_ctrl.md
# pong_session_ctrl

Match-level controller that sits between the input bridge and `pong_logic` in the pong engine. It owns the session state machine: title, serve countdown, play, game over, and an attract demo. It also owns scoring against a parametrised win threshold, and it generates the paddle commands. Paddle commands come from the human buttons or from a per-paddle CPU tracker, depending on `mode_sel` and attract state. It runs entirely in the pixel-clock domain and advances its timers only on the per-frame tick.

## Interface

Parameters:
- `WIN_SCORE`, 9: points needed to win; legal range 1..15.
- `SERVE_FRAMES`, 60: frames of serve countdown before the ball is released.
- `IDLE_FRAMES`, 1800: idle frames in TITLE or GAME_OVER before attract starts.
- `CPU_REACTION`, 4: frame delay of ball-y seen by the CPU tracker; legal range 1..8.
- `CPU_DEADBAND`, 4: pixel deadband around the paddle centre.
- `PADDLE_H`, 48: paddle height in pixels.
- `BALL_H`, 8: ball height in pixels.

Ports:
- `clk_0` in 1: 25.175 MHz pixel clock.
- `rst` in 1: reset; synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame.
- `btn_p1_up`, `btn_p1_down`, `btn_p2_up`, `btn_p2_down` in 1 each: debounced button levels.
- `mode_sel` in 2: 00 = 2P, 01 = P1 vs CPU (P2 is CPU), 10 = CPU vs CPU, 11 = treated as 00.
- `sq_ypos` in 10: ball top y.
- `pdl1_ypos`, `pdl2_ypos` in 10: paddle top y.
- `point_p1`, `point_p2` in 1: one-cycle pulse when that player scores.
- `up_p1`, `down_p1`, `up_p2`, `down_p2` out 1: paddle commands to `pong_logic`.
- `score_p1`, `score_p2` out 4: current scores.
- `serve_en` out 1: ball released; high only in PLAY.
- `game_startup` out 1: high in TITLE.
- `game_over` out 1: high in GAME_OVER.
- `attract` out 1: demo session active.

## Operation

States are TITLE, SERVE, PLAY and GAME_OVER. Reset state is TITLE.

- `any_btn` is the OR of the four buttons. A start edge is a rising edge of `any_btn`. `any_prev` resets to 1, so a button held through reset does not start a game.

TITLE:
- Start edge -> SERVE; scores cleared; `attract`=0.
- Otherwise the idle counter advances per `frame_tick`. At `IDLE_FRAMES` -> SERVE with `attract`=1 and scores cleared.

SERVE:
- Countdown loaded with `SERVE_FRAMES` on entry and decremented per `frame_tick`.
- At 0 -> PLAY.

PLAY:
- `point_p1` alone -> `score_p1`+1. `point_p2` alone -> `score_p2`+1.
- Both pulses in the same cycle count as a let: no score change, -> SERVE.
- After an increment: the new score equals `WIN_SCORE` -> GAME_OVER, otherwise -> SERVE.

GAME_OVER:
- Scores frozen.
- Start edge -> TITLE with `attract`=0; scores are kept until the next start.
- Idle counter reaching `IDLE_FRAMES` -> TITLE.

Attract:
- In any state with `attract`=1, a start edge clears the scores, clears `attract` and forces TITLE. That edge does not also start a game.
- Attract GAME_OVER -> TITLE after `IDLE_FRAMES`. The idle counter then resets, so attract re-enters after another `IDLE_FRAMES`.

Point pulses outside PLAY are ignored.

Paddle source:
- Paddle 1 is CPU when `attract`=1 or `mode_sel`=10.
- Paddle 2 is CPU when `attract`=1 or `mode_sel` is 01 or 10.
- All other paddles are human.

Human paddle:
- up = btn_up AND NOT btn_down; down = btn_down AND NOT btn_up.
- Both pressed -> both 0.

CPU tracker:
- Ball history: on each `frame_tick`, `sq_ypos` is pushed into a `CPU_REACTION`-deep shift register.
- Target: the oldest entry plus `BALL_H`/2.
- Centre: paddle y plus `PADDLE_H`/2.
- Difference: 11-bit signed, target minus centre.
  - Greater than `CPU_DEADBAND` -> down.
  - Less than -`CPU_DEADBAND` -> up.
  - Otherwise neither.
- CPU commands update only on `frame_tick` and are held between ticks.
- The history resets to 0.

Paddle commands are forced to 0 outside SERVE and PLAY.

## Timing

- Every output is registered.

Reset values:
- State TITLE; `game_startup`=1.
- `game_over`, `serve_en` and `attract` = 0.
- Scores 0; all paddle commands 0.
- Counters and CPU history 0.

Latencies:
- Button to human paddle command: 1 cycle.
- Point pulse to score update and state change: 1 cycle.
- `frame_tick` to CPU command update: 1 cycle.
- State-decoded outputs follow the state register, with no extra cycle.

Boundary behaviour:
- `serve_en` rises on the cycle after the serve counter reaches 0, and falls on the cycle after a point is registered.
- Score never exceeds `WIN_SCORE`: GAME_OVER is entered on the same update that reaches it, and the 4-bit counter does not wrap.
- A `mode_sel` change takes effect on the next cycle. For a CPU paddle it takes effect on the next `frame_tick`. No state or score change results.
- `rst` mid-game returns TITLE and clears all scores within 1 cycle.

## Test plan

- **Start:** reset with `btn_p1_up` held, then release and press again -> no start while held. `game_startup` falls 1 cycle after the second press, `serve_en` rises after exactly 60 `frame_tick`s.
- **Scoring and win:** `WIN_SCORE`=3, 2P mode. Pulse `point_p1` three times, each in PLAY. Pulse `point_p2` once while in SERVE. Required: `score_p1`=3, `score_p2`=0, `game_over`=1; a following `point_p1` leaves `score_p1`=3.
- **Simultaneous points:** `point_p1` and `point_p2` in the same PLAY cycle -> scores unchanged, state SERVE, `serve_en`=0 the next cycle.
- **CPU tracking:** `mode_sel`=01, `pdl2_ypos`=200, `sq_ypos`=300 held for 4 ticks -> `down_p2`=1 after the 4th tick. With `sq_ypos`=216 (target 220, paddle centre 224, within the deadband) -> `up_p2`=`down_p2`=0.
- **Attract:** `IDLE_FRAMES`=10, no input. `attract`=1 after 10 ticks and both paddles are CPU-driven. A button press -> `attract`=0, TITLE, scores 0, and no game starts until the next press.
- **Conflicting buttons:** `btn_p1_up`=`btn_p1_down`=1 in PLAY -> `up_p1`=`down_p1`=0.
